// File: rtl/pr_if_id_skid_if.sv
// IF/ID skid-buffer bus: IF-side offer/accept handshake, flush, and ID-side head entry.
// The slave modport is the view the pipeline register itself takes. The master modport
// is the view of the surrounding pipeline, which drives the inputs and observes the
// outputs.
interface pr_if_id_skid_if #(
    parameter int unsigned INSTR_W = 32,
    parameter int unsigned PC_W    = 32
);
    logic               in_valid;
    logic               in_ready;
    logic [INSTR_W-1:0] instru_in;
    logic [PC_W-1:0]    nextpc_in;
    logic               flush;
    logic               out_valid;
    logic               out_ready;
    logic [INSTR_W-1:0] instru;
    logic [5:0]         ctr;
    logic [5:0]         funcode;
    logic [PC_W-1:0]    nextpc;
    logic [PC_W-1:0]    normal_nextpc;

    modport master (
        output in_valid, instru_in, nextpc_in, flush, out_ready,
        input  in_ready, out_valid, instru, ctr, funcode, nextpc, normal_nextpc
    );

    modport slave (
        input  in_valid, instru_in, nextpc_in, flush, out_ready,
        output in_ready, out_valid, instru, ctr, funcode, nextpc, normal_nextpc
    );
endinterface

// File: rtl/pr_if_id_skid.sv
// IF/ID pipeline register with a one-entry skid buffer (two entries, in-order).
// in_ready comes only from the state register, so it has no combinational path
// from out_ready.
// Optional feature: define PR_IF_ID_SKID_PERF_EN to add saturating stall_cnt and
// flush_cnt outputs.
module pr_if_id_skid #(
    parameter int unsigned        INSTR_W   = 32,
    parameter int unsigned        PC_W      = 32,
    parameter logic [INSTR_W-1:0] NOP_INSTR = INSTR_W'(32'hFC00_0000),
    parameter int unsigned        PC_INC    = 4
) (
    input logic            clk,
    input logic            rst_n,
    pr_if_id_skid_if.slave bus
`ifdef PR_IF_ID_SKID_PERF_EN
    ,
    output logic [15:0]    stall_cnt,
    output logic [15:0]    flush_cnt
`endif
);

    typedef enum logic [1:0] {StEmpty, StOne, StFull} state_e;

    state_e             state_q, state_d;
    logic [INSTR_W-1:0] head_instr_q, skid_instr_q;
    logic [PC_W-1:0]    head_pc_q, skid_pc_q;
    logic [PC_W-1:0]    head_npc_q, skid_npc_q;
    logic               load_head, head_from_skid, load_skid;
    logic               accept, pop;
    logic [PC_W-1:0]    in_npc;
    logic [INSTR_W-1:0] instr_mux;

    assign bus.in_ready  = (state_q != StFull);
    assign bus.out_valid = (state_q != StEmpty);
    assign accept        = bus.in_valid && bus.in_ready;
    assign pop           = bus.out_valid && bus.out_ready;
    // The sequential PC is computed on entry so the ID side sees a registered value.
    assign in_npc        = bus.nextpc_in + PC_W'(PC_INC);

    // Occupancy next-state and register load selects; flush overrides everything.
    always_comb begin
        state_d        = state_q;
        load_head      = 1'b0;
        head_from_skid = 1'b0;
        load_skid      = 1'b0;
        if (bus.flush) begin
            state_d = StEmpty;
        end else begin
            unique case (state_q)
                StEmpty: begin
                    if (accept) begin
                        load_head = 1'b1;
                        state_d   = StOne;
                    end
                end
                StOne: begin
                    if (accept && pop) begin
                        load_head = 1'b1;
                    end else if (accept) begin
                        load_skid = 1'b1;
                        state_d   = StFull;
                    end else if (pop) begin
                        state_d = StEmpty;
                    end
                end
                StFull: begin
                    if (pop) begin
                        load_head      = 1'b1;
                        head_from_skid = 1'b1;
                        state_d        = StOne;
                    end
                end
                default: state_d = StEmpty;
            endcase
        end
    end

    // State and entry storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StEmpty;
            head_instr_q <= '0;
            head_pc_q    <= '0;
            head_npc_q   <= '0;
            skid_instr_q <= '0;
            skid_pc_q    <= '0;
            skid_npc_q   <= '0;
        end else begin
            state_q <= state_d;
            if (load_head) begin
                head_instr_q <= head_from_skid ? skid_instr_q : bus.instru_in;
                head_pc_q    <= head_from_skid ? skid_pc_q    : bus.nextpc_in;
                head_npc_q   <= head_from_skid ? skid_npc_q   : in_npc;
            end
            if (load_skid) begin
                skid_instr_q <= bus.instru_in;
                skid_pc_q    <= bus.nextpc_in;
                skid_npc_q   <= in_npc;
            end
        end
    end

    // Head outputs; a bubble with zeroed PCs is presented whenever no entry is held.
    always_comb begin
        instr_mux         = bus.out_valid ? head_instr_q : NOP_INSTR;
        bus.instru        = instr_mux;
        bus.ctr           = instr_mux[31:26];
        bus.funcode       = instr_mux[5:0];
        bus.nextpc        = bus.out_valid ? head_pc_q  : '0;
        bus.normal_nextpc = bus.out_valid ? head_npc_q : '0;
    end

`ifdef PR_IF_ID_SKID_PERF_EN
    logic [15:0] stall_cnt_q, flush_cnt_q;

    // Saturating counters for back-pressure cycles and flush cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (bus.out_valid && !bus.out_ready && stall_cnt_q != 16'hFFFF) begin
                stall_cnt_q <= stall_cnt_q + 16'd1;
            end
            if (bus.flush && flush_cnt_q != 16'hFFFF) begin
                flush_cnt_q <= flush_cnt_q + 16'd1;
            end
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pr_if_id_skid.sv
// Directed bench for pr_if_id_skid; each scenario task does its own inline checks.
module tb_pr_if_id_skid;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_bad;

    pr_if_id_skid_if #(.INSTR_W(32), .PC_W(32)) bus ();

`ifdef PR_IF_ID_SKID_PERF_EN
    logic [15:0] stall_cnt;
    logic [15:0] flush_cnt;
`endif

    pr_if_id_skid #(
        .INSTR_W  (32),
        .PC_W     (32),
        .NOP_INSTR(32'hFC00_0000),
        .PC_INC   (4)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
`ifdef PR_IF_ID_SKID_PERF_EN
        ,
        .stall_cnt(stall_cnt),
        .flush_cnt(flush_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                         input logic ordy, input logic fl);
        bus.in_valid  = v;
        bus.instru_in = ins;
        bus.nextpc_in = pc;
        bus.out_ready = ordy;
        bus.flush     = fl;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        #1;
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++;
            $display("FAIL rst_out_valid got %b want 0", bus.out_valid); end
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_bad++;
            $display("FAIL rst_in_ready got %b want 1", bus.in_ready); end
        n_cmp++; if (bus.instru !== 32'hFC00_0000) begin n_bad++;
            $display("FAIL rst_instru got %h want fc000000", bus.instru); end
        n_cmp++; if (bus.normal_nextpc !== 32'h0 || bus.nextpc !== 32'h0) begin n_bad++;
            $display("FAIL rst_pcs got %h/%h want 0/0", bus.nextpc, bus.normal_nextpc); end
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        n_cmp++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin n_bad++;
            $display("FAIL idle_hs got v=%b r=%b want 0/1", bus.out_valid, bus.in_ready); end
        n_cmp++; if (bus.ctr !== 6'h3F || bus.funcode !== 6'h00) begin n_bad++;
            $display("FAIL idle_fields got ctr=%h fc=%h want 3f/00", bus.ctr, bus.funcode); end
        n_cmp++; if (bus.instru !== 32'hFC00_0000) begin n_bad++;
            $display("FAIL idle_instru got %h want fc000000", bus.instru); end
    endtask

    task automatic test_single();
        drive(1'b1, 32'h2002_0005, 32'h0000_0004, 1'b1, 1'b0);
        tick();
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        n_cmp++; if (bus.out_valid !== 1'b1) begin n_bad++;
            $display("FAIL single_valid got %b want 1", bus.out_valid); end
        n_cmp++; if (bus.ctr !== 6'h08 || bus.funcode !== 6'h05) begin n_bad++;
            $display("FAIL single_fields got ctr=%h fc=%h want 08/05", bus.ctr, bus.funcode); end
        n_cmp++; if (bus.normal_nextpc !== 32'h8 || bus.nextpc !== 32'h4) begin n_bad++;
            $display("FAIL single_pcs got %h/%h want 4/8", bus.nextpc, bus.normal_nextpc); end
        n_cmp++; if (bus.instru !== 32'h2002_0005) begin n_bad++;
            $display("FAIL single_instru got %h want 20020005", bus.instru); end
        tick();
        n_cmp++; if (bus.out_valid !== 1'b0 || bus.instru !== 32'hFC00_0000) begin n_bad++;
            $display("FAIL single_drain got v=%b i=%h want 0/fc000000", bus.out_valid,
                     bus.instru); end
    endtask

    task automatic test_back_to_back();
        drive(1'b1, 32'hAAAA_0001, 32'h0000_1000, 1'b0, 1'b0);
        tick();
        drive(1'b1, 32'hBBBB_0002, 32'h0000_2000, 1'b0, 1'b0);
        n_cmp++; if (bus.in_ready !== 1'b1 || bus.instru !== 32'hAAAA_0001) begin n_bad++;
            $display("FAIL b2b_one got r=%b i=%h want 1/aaaa0001", bus.in_ready, bus.instru); end
        tick();
        drive(1'b1, 32'hCCCC_0003, 32'h0000_3000, 1'b0, 1'b0);
        n_cmp++; if (bus.in_ready !== 1'b0) begin n_bad++;
            $display("FAIL b2b_full_ready got %b want 0", bus.in_ready); end
        tick();
        n_cmp++; if (bus.instru !== 32'hAAAA_0001 || bus.normal_nextpc !== 32'h1004)
            begin n_bad++;
            $display("FAIL b2b_stable got %h/%h want aaaa0001/1004", bus.instru,
                     bus.normal_nextpc); end
        bus.out_ready = 1'b1;
        tick();
        n_cmp++; if (bus.instru !== 32'hBBBB_0002 || bus.nextpc !== 32'h2000) begin n_bad++;
            $display("FAIL b2b_second got %h/%h want bbbb0002/2000", bus.instru,
                     bus.nextpc); end
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_bad++;
            $display("FAIL b2b_ready_back got %b want 1", bus.in_ready); end
        tick();
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        n_cmp++; if (bus.out_valid !== 1'b1 || bus.instru !== 32'hCCCC_0003) begin n_bad++;
            $display("FAIL b2b_third got v=%b i=%h want 1/cccc0003", bus.out_valid,
                     bus.instru); end
        tick();
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++;
            $display("FAIL b2b_drain got %b want 0", bus.out_valid); end
    endtask

    task automatic test_wrap();
        drive(1'b1, 32'h1234_5678, 32'hFFFF_FFFC, 1'b1, 1'b0);
        tick();
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        n_cmp++; if (bus.normal_nextpc !== 32'h0 || bus.nextpc !== 32'hFFFF_FFFC)
            begin n_bad++;
            $display("FAIL wrap_npc got %h/%h want fffffffc/0", bus.nextpc,
                     bus.normal_nextpc); end
        tick();
    endtask

    task automatic test_flush();
        drive(1'b1, 32'h1111_0001, 32'h100, 1'b0, 1'b0);
        tick();
        drive(1'b1, 32'h2222_0002, 32'h200, 1'b0, 1'b0);
        tick();
        drive(1'b1, 32'hDDDD_0004, 32'h400, 1'b1, 1'b1);
        n_cmp++; if (bus.in_ready !== 1'b0) begin n_bad++;
            $display("FAIL flush_pre_full got %b want 0", bus.in_ready); end
        tick();
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        n_cmp++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin n_bad++;
            $display("FAIL flush_empty got v=%b r=%b want 0/1", bus.out_valid,
                     bus.in_ready); end
        n_cmp++; if (bus.instru !== 32'hFC00_0000) begin n_bad++;
            $display("FAIL flush_instru got %h want fc000000", bus.instru); end
        tick();
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++;
            $display("FAIL flush_no_deliver got %b want 0", bus.out_valid); end
        // Flush while holding one entry also discards a same-cycle accept.
        drive(1'b1, 32'h3333_0003, 32'h300, 1'b0, 1'b0);
        tick();
        drive(1'b1, 32'h4444_0004, 32'h400, 1'b0, 1'b1);
        tick();
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++;
            $display("FAIL flush_one got %b want 0", bus.out_valid); end
        tick();
    endtask

    task automatic test_mid_reset();
        drive(1'b1, 32'h5555_0005, 32'h500, 1'b0, 1'b0);
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin n_bad++;
            $display("FAIL midrst_hs got v=%b r=%b want 0/1", bus.out_valid,
                     bus.in_ready); end
        tick();
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++;
            $display("FAIL midrst_no_accept got %b want 0", bus.out_valid); end
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        rst_n = 1'b1;
        tick();
        n_cmp++; if (bus.out_valid !== 1'b0 || bus.instru !== 32'hFC00_0000) begin n_bad++;
            $display("FAIL midrst_after got v=%b i=%h want 0/fc000000", bus.out_valid,
                     bus.instru); end
    endtask

`ifdef PR_IF_ID_SKID_PERF_EN
    task automatic test_perf();
        rst_n = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        tick();
        rst_n = 1'b1;
        n_cmp++; if (stall_cnt !== 16'd0 || flush_cnt !== 16'd0) begin n_bad++;
            $display("FAIL perf_rst got %0d/%0d want 0/0", stall_cnt, flush_cnt); end
        drive(1'b1, 32'h6666_0006, 32'h600, 1'b0, 1'b0);
        tick();
        bus.in_valid = 1'b0;
        repeat (5) tick();
        n_cmp++; if (stall_cnt !== 16'd5) begin n_bad++;
            $display("FAIL perf_stall got %0d want 5", stall_cnt); end
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b1);
        tick();
        tick();
        bus.flush = 1'b0;
        tick();
        n_cmp++; if (flush_cnt !== 16'd2 || stall_cnt !== 16'd5) begin n_bad++;
            $display("FAIL perf_flush got f=%0d s=%0d want 2/5", flush_cnt, stall_cnt); end
    endtask
`endif

    initial begin
        n_cmp = 0;
        n_bad = 0;
        test_reset();
        test_single();
        test_back_to_back();
        test_wrap();
        test_flush();
        test_mid_reset();
`ifdef PR_IF_ID_SKID_PERF_EN
        test_perf();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
